rtc_bus_cycle: RTL and testbench
================================

Name: rtc_bus_cycle

Overview:
- Physical bus engine for the parallel RTC interface: one byte read or write per request on the multiplexed A/D bus (reg_a_d, reg_cs, reg_rd, reg_wr, dato).
- Sits directly downstream of the digital-clock controller, which issues address, data and direction and waits for done.
- Generates phase timing with cycle counters, drives and releases the tri-state bus, and captures read data.

Parameters:
- T_SETUP, 2, cycles CS/A-D/bus are valid before a strobe (>=1)
- T_STROBE, 4, cycles a strobe (RD or WR) is held low (>=1)
- T_HOLD, 2, cycles bus/CS are held after strobe release (>=1)
- T_GAP, 2, idle cycles between the address phase and the data phase (>=1)
- CNT_W, 8, phase counter width; every T_* must be < 2**CNT_W

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; accepted only in IDLE
- rw  in  1  1=read, 0=write; latched on accept
- addr  in  8  RTC register address; latched on accept
- wdata  in  8  write data; latched on accept
- rdata  out  8  captured read data; holds until the next read completes
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse when the transaction finishes
- reg_a_d  out  1  0=address phase, 1=data phase; idle 1
- reg_cs  out  1  chip select, active low; idle 1
- reg_rd  out  1  read strobe, active low; idle 1
- reg_wr  out  1  write strobe, active low; idle 1
- dato  inout  8  multiplexed A/D bus; high-Z unless this block drives it

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: FSM=IDLE, rdata=0x00, busy=0, done=0, reg_a_d=1, reg_cs=1, reg_rd=1, reg_wr=1, dato=Z.
- All strobe and bus-enable outputs are registered (glitch-free).
- States and outputs (each state lasts its T_* cycles; the counter reloads on entry and the state exits when the counter reaches its terminal count):
  - IDLE: wait for start.
  - A_SETUP (T_SETUP): a_d=0, cs=0, dato=addr.
  - A_STROBE (T_STROBE): as A_SETUP, plus wr=0. The address is latched by the RTC on the WR rising edge.
  - A_HOLD (T_HOLD): wr=1, dato=addr, cs=0.
  - GAP (T_GAP): cs=1, a_d=1, dato=Z.
  - D_SETUP (T_SETUP): cs=0, a_d=1. dato=wdata for a write; Z for a read.
  - D_STROBE (T_STROBE): rd=0 for a read, wr=0 for a write.
  - D_HOLD (T_HOLD): strobes=1, cs=0, bus as in D_SETUP.
  - Then IDLE.
- Read capture: dato is sampled into rdata at the clock edge that ends the last D_STROBE cycle. rdata is unchanged on writes.
- Latency with defaults: start sampled at edge k.
  - busy is high for cycles k+1..k+18 (2*(T_SETUP+T_STROBE+T_HOLD)+T_GAP).
  - done is high in cycle k+19 (the first IDLE cycle), with busy low.
- start while busy: ignored, with no effect on latched inputs.
- start in the done cycle: accepted; the next transaction begins the following cycle.
- reset mid-transaction: the next edge forces IDLE and reset values; no done pulse; rdata is cleared.
- Bus contention guard: dato is never driven in GAP or IDLE, nor during a read data phase.

Optional Feature:
- Macro: RTC_BUS_TXN_CNT_EN.
- Defined:
  - Adds output txn_cnt[15:0], which increments on every done pulse and wraps 0xFFFF->0x0000.
  - Cleared by reset.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Package rtc_bus_pkg:
  - FSM state enum (IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD).
  - RW_READ/RW_WRITE constants.
  - Default timing constants.
- Sub-module rtc_phase_timer:
  - Loadable CNT_W down-counter with load value and terminal-count output.
  - Instantiated once; the FSM drives load at each state entry.

Test Plan:
- Write: addr=0x21, wdata=0x45, rw=0.
  - Address phase: dato=0x21 with a_d=0 and cs=0; wr low for 4 cycles.
  - Data phase: dato=0x45 with a_d=1; wr low for 4 cycles; rd stays 1.
  - done at k+19; rdata stays 0x00.
- Read: addr=0x22, rw=1; bench drives dato=0x59 only while rd=0.
  - Block drives dato only in the address phase; rd low for 4 cycles.
  - rdata=0x59 at k+19, coincident with done.
- Busy rejection: second start with addr=0x33 at k+5.
  - Ignored; the bus still carries 0x21; exactly one done pulse.
- Back-to-back: start asserted in the done cycle of transaction 1.
  - The A_SETUP of transaction 2 begins the next cycle.
  - busy low for exactly that one cycle.
- Reset mid-operation: reset at k+12 during D_SETUP.
  - Next cycle: all strobes=1, cs=1, a_d=1, dato=Z, busy=0, no done.
  - A fresh start afterwards completes normally.
- Parameter corner: T_SETUP=T_STROBE=T_HOLD=T_GAP=1.
  - busy for 7 cycles; each strobe low exactly 1 cycle.
  - With RTC_BUS_TXN_CNT_EN defined: txn_cnt increments by 1 per done.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the parallel RTC bus engine.
//   state_e  : bus-cycle FSM states
//   RW_*     : direction encoding of the rw request input
//   DEF_*    : default phase timing (clock cycles) and phase-counter width
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_STROBE,
        ST_A_HOLD,
        ST_GAP,
        ST_D_SETUP,
        ST_D_STROBE,
        ST_D_HOLD
    } state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int unsigned DEF_T_SETUP  = 2;
    localparam int unsigned DEF_T_STROBE = 4;
    localparam int unsigned DEF_T_HOLD   = 2;
    localparam int unsigned DEF_T_GAP    = 2;
    localparam int unsigned DEF_CNT_W    = 8;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that times one bus-cycle phase.
//   clk, reset : clock, synchronous active-high reset
//   load       : reload the counter with load_val (phase entry)
//   load_val   : phase length minus one
//   tc_c       : terminal count, high in the last cycle of the phase
module rtc_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc_c
);

    logic [CNT_W-1:0] r_cnt;

    // Counts down to zero and parks there until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign tc_c = (r_cnt == '0);

endmodule

// File: rtl/rtc_bus_cycle.sv
// Physical bus engine for the parallel RTC interface: one byte read or
// write per request on the multiplexed A/D bus.
//   clk, reset          : clock, synchronous active-high reset
//   start, rw, addr,
//   wdata               : request (latched when accepted in IDLE)
//   rdata               : last captured read byte
//   busy, done          : transaction in flight / one-cycle completion pulse
//   reg_a_d, reg_cs,
//   reg_rd, reg_wr      : RTC control pins (all registered, active low
//                         except reg_a_d: 0=address, 1=data)
//   dato                : tri-state multiplexed A/D bus
//   txn_cnt             : completed-transaction count, only present when
//                         RTC_BUS_TXN_CNT_EN is defined
module rtc_bus_cycle
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_SETUP  = DEF_T_SETUP,
    parameter int unsigned T_STROBE = DEF_T_STROBE,
    parameter int unsigned T_HOLD   = DEF_T_HOLD,
    parameter int unsigned T_GAP    = DEF_T_GAP,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rw,
    input  logic [7:0]  addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        done,
    output logic        reg_a_d,
    output logic        reg_cs,
    output logic        reg_rd,
    output logic        reg_wr,
    inout  wire  [7:0]  dato
`ifdef RTC_BUS_TXN_CNT_EN
    ,
    output logic [15:0] txn_cnt
`endif
);

    state_e           r_state;
    logic             r_rw;
    logic [7:0]       r_addr;
    logic [7:0]       r_wdata;
    logic [7:0]       r_rdata;
    logic             r_busy;
    logic             r_done;
    logic             r_a_d;
    logic             r_cs;
    logic             r_rd;
    logic             r_wr;
    logic             r_oe;
    logic [7:0]       r_dout;

    state_e           w_next_state;
    logic             w_tc;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_accept;
    logic             w_rw_n;
    logic [7:0]       w_addr_n;
    logic [7:0]       w_wdata_n;
    logic             w_a_d_n;
    logic             w_cs_n;
    logic             w_rd_n;
    logic             w_wr_n;
    logic             w_oe_n;
    logic [7:0]       w_dout_n;
    logic             w_done_n;
    logic             w_capture;

    // Phase length minus one, loaded into the timer on state entry.
    function automatic logic [CNT_W-1:0] phase_len(input state_e s);
        case (s)
            ST_A_SETUP, ST_D_SETUP:   phase_len = CNT_W'(T_SETUP - 1);
            ST_A_STROBE, ST_D_STROBE: phase_len = CNT_W'(T_STROBE - 1);
            ST_A_HOLD, ST_D_HOLD:     phase_len = CNT_W'(T_HOLD - 1);
            ST_GAP:                   phase_len = CNT_W'(T_GAP - 1);
            default:                  phase_len = '0;
        endcase
    endfunction

    rtc_phase_timer #(
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .tc_c     (w_tc)
    );

    // Next-state logic; each timed phase advances on terminal count.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (start) w_next_state = ST_A_SETUP;
            ST_A_SETUP:  if (w_tc)  w_next_state = ST_A_STROBE;
            ST_A_STROBE: if (w_tc)  w_next_state = ST_A_HOLD;
            ST_A_HOLD:   if (w_tc)  w_next_state = ST_GAP;
            ST_GAP:      if (w_tc)  w_next_state = ST_D_SETUP;
            ST_D_SETUP:  if (w_tc)  w_next_state = ST_D_STROBE;
            ST_D_STROBE: if (w_tc)  w_next_state = ST_D_HOLD;
            ST_D_HOLD:   if (w_tc)  w_next_state = ST_IDLE;
            default:                w_next_state = ST_IDLE;
        endcase
    end

    assign w_load     = (w_next_state != r_state);
    assign w_load_val = phase_len(w_next_state);
    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_done_n   = (r_state == ST_D_HOLD) && w_tc;
    assign w_capture  = (r_state == ST_D_STROBE) && w_tc && (r_rw == RW_READ);

    // Request fields as they will be latched, so pin decode on the accept
    // edge already sees the new transaction.
    assign w_rw_n    = w_accept ? rw    : r_rw;
    assign w_addr_n  = w_accept ? addr  : r_addr;
    assign w_wdata_n = w_accept ? wdata : r_wdata;

    // Pin decode from the next state; the result is registered so every
    // strobe and the bus enable change only on a clock edge.
    always_comb begin
        w_a_d_n  = 1'b1;
        w_cs_n   = 1'b1;
        w_rd_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_oe_n   = 1'b0;
        w_dout_n = w_addr_n;
        case (w_next_state)
            ST_A_SETUP, ST_A_HOLD: begin
                w_a_d_n = 1'b0;
                w_cs_n  = 1'b0;
                w_oe_n  = 1'b1;
            end
            ST_A_STROBE: begin
                w_a_d_n = 1'b0;
                w_cs_n  = 1'b0;
                w_wr_n  = 1'b0;
                w_oe_n  = 1'b1;
            end
            ST_D_SETUP, ST_D_HOLD: begin
                w_cs_n   = 1'b0;
                w_oe_n   = (w_rw_n == RW_WRITE);
                w_dout_n = w_wdata_n;
            end
            ST_D_STROBE: begin
                w_cs_n   = 1'b0;
                w_rd_n   = (w_rw_n != RW_READ);
                w_wr_n   = (w_rw_n != RW_WRITE);
                w_oe_n   = (w_rw_n == RW_WRITE);
                w_dout_n = w_wdata_n;
            end
            default: ;
        endcase
    end

    // State, latched request and registered pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_rw    <= RW_WRITE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_a_d   <= 1'b1;
            r_cs    <= 1'b1;
            r_rd    <= 1'b1;
            r_wr    <= 1'b1;
            r_oe    <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_next_state;
            r_rw    <= w_rw_n;
            r_addr  <= w_addr_n;
            r_wdata <= w_wdata_n;
            if (w_capture) begin
                r_rdata <= dato;
            end
            r_busy  <= (w_next_state != ST_IDLE);
            r_done  <= w_done_n;
            r_a_d   <= w_a_d_n;
            r_cs    <= w_cs_n;
            r_rd    <= w_rd_n;
            r_wr    <= w_wr_n;
            r_oe    <= w_oe_n;
            r_dout  <= w_dout_n;
        end
    end

    assign rdata   = r_rdata;
    assign busy    = r_busy;
    assign done    = r_done;
    assign reg_a_d = r_a_d;
    assign reg_cs  = r_cs;
    assign reg_rd  = r_rd;
    assign reg_wr  = r_wr;
    assign dato    = r_oe ? r_dout : 8'bz;

`ifdef RTC_BUS_TXN_CNT_EN
    logic [15:0] r_txn_cnt;

    // Advances together with the done pulse; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_txn_cnt <= '0;
        end else if (w_done_n) begin
            r_txn_cnt <= r_txn_cnt + 16'd1;
        end
    end

    assign txn_cnt = r_txn_cnt;
`endif

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Self-checking bench for rtc_bus_cycle: default-timing instance plus an
// all-ones timing instance. Read data is supplied on the bus only while
// the read strobe is low; the bus floats high otherwise.
module tb_rtc_bus_cycle;
    import rtc_bus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, rw;
    logic [7:0]  addr, wdata, rdata;
    logic        busy, done, reg_a_d, reg_cs, reg_rd, reg_wr;
    tri1  [7:0]  dato;
    logic [7:0]  tb_rdval = 8'h59;
    assign dato = (reg_rd == 1'b0) ? tb_rdval : 8'bz;

    logic        c_start, c_rw;
    logic [7:0]  c_addr, c_wdata, c_rdata;
    logic        c_busy, c_done, c_a_d, c_cs, c_rd, c_wr;
    tri1  [7:0]  c_dato;
    assign c_dato = (c_rd == 1'b0) ? 8'hA7 : 8'bz;

`ifdef RTC_BUS_TXN_CNT_EN
    logic [15:0] txn_cnt, c_txn_cnt;
`endif

    rtc_bus_cycle u_dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr),
        .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .reg_a_d(reg_a_d), .reg_cs(reg_cs), .reg_rd(reg_rd), .reg_wr(reg_wr),
        .dato(dato)
`ifdef RTC_BUS_TXN_CNT_EN
        , .txn_cnt(txn_cnt)
`endif
    );

    rtc_bus_cycle #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .T_GAP(1)) u_dut_c (
        .clk(clk), .reset(reset), .start(c_start), .rw(c_rw), .addr(c_addr),
        .wdata(c_wdata), .rdata(c_rdata), .busy(c_busy), .done(c_done),
        .reg_a_d(c_a_d), .reg_cs(c_cs), .reg_rd(c_rd), .reg_wr(c_wr),
        .dato(c_dato)
`ifdef RTC_BUS_TXN_CNT_EN
        , .txn_cnt(c_txn_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: expected rdata at each done, pushed when start is driven.
    logic [7:0] sb_q[$];
    logic [7:0] model_rdata = 8'h00;
    logic       cur_rw;
    logic [7:0] cur_addr, cur_wdata;

    // Per-transaction observations gathered by watch_txn.
    int         n_busy, n_ad0, n_addr_bad, n_addr_wr, n_data_wr, n_rd_low;
    int         n_data_bad, n_float_bad, done_idx;
    logic       done_busy, first_busy, first_cs, first_ad;
    logic [7:0] first_dato, rdata_at_done, exp_done;

    task automatic drive_start(input logic rw_i, input logic [7:0] a, input logic [7:0] w);
        rw = rw_i; addr = a; wdata = w; start = 1'b1;
        if (rw_i == RW_READ) model_rdata = tb_rdval;
        sb_q.push_back(model_rdata);
        cur_rw = rw_i; cur_addr = a; cur_wdata = w;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic watch_txn(input int inject_at, input logic chain, input logic ch_rw,
                             input logic [7:0] ch_a, input logic [7:0] ch_w);
        n_busy = 0; n_ad0 = 0; n_addr_bad = 0; n_addr_wr = 0; n_data_wr = 0;
        n_rd_low = 0; n_data_bad = 0; n_float_bad = 0; done_idx = -1;
        done_busy = 1'bx; rdata_at_done = 8'hxx; exp_done = 8'hxx;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j == 1) begin
                first_busy = busy; first_cs = reg_cs; first_ad = reg_a_d; first_dato = dato;
            end
            if (j == inject_at + 1) start = 1'b0;
            if (busy) n_busy++;
            if (reg_rd == 1'b0) n_rd_low++;
            if (reg_a_d == 1'b0) begin
                n_ad0++;
                if (reg_cs !== 1'b0 || dato !== cur_addr) n_addr_bad++;
                if (reg_wr == 1'b0) n_addr_wr++;
            end else if (reg_cs == 1'b0) begin
                if (reg_wr == 1'b0) n_data_wr++;
                if (cur_rw == RW_WRITE && dato !== cur_wdata) n_data_bad++;
                if (cur_rw == RW_READ && reg_rd == 1'b1 && dato !== 8'hFF) n_float_bad++;
            end else if (dato !== 8'hFF) begin
                n_float_bad++;
            end
            if (j == inject_at) begin
                rw = 1'b1; addr = 8'h33; wdata = 8'hEE; start = 1'b1;
            end
            if (done) begin
                done_idx = j; done_busy = busy; rdata_at_done = rdata;
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL sb_underflow: done with no expected entry");
                end else begin
                    exp_done = sb_q.pop_front();
                end
                if (chain) drive_start(ch_rw, ch_a, ch_w);
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        c_start = 1'b0; c_rw = 1'b0; c_addr = '0; c_wdata = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, reg_a_d, reg_cs, reg_rd, reg_wr} !== 6'b001111) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 001111", {busy, done, reg_a_d, reg_cs, reg_rd, reg_wr});
        end
        n_checks++;
        if (rdata !== 8'h00 || dato !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_bus: rdata=%h dato=%h expected 00/FF (undriven)", rdata, dato);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        drive_start(RW_WRITE, 8'h21, 8'h45);
        watch_txn(0, 1'b0, 1'b0, 8'h00, 8'h00);
        n_checks++;
        if (n_ad0 !== 8 || n_addr_bad !== 0) begin
            n_fail++; $display("FAIL wr_addr_phase: cycles=%0d bad=%0d expected 8/0", n_ad0, n_addr_bad);
        end
        n_checks++;
        if (n_addr_wr !== 4 || n_data_wr !== 4) begin
            n_fail++; $display("FAIL wr_strobes: addr=%0d data=%0d expected 4/4", n_addr_wr, n_data_wr);
        end
        n_checks++;
        if (n_rd_low !== 0 || n_data_bad !== 0 || n_float_bad !== 0) begin
            n_fail++; $display("FAIL wr_bus: rd_low=%0d data_bad=%0d float_bad=%0d expected 0/0/0", n_rd_low, n_data_bad, n_float_bad);
        end
        n_checks++;
        if (n_busy !== 18 || done_idx !== 19 || done_busy !== 1'b0) begin
            n_fail++; $display("FAIL wr_latency: busy=%0d done_at=%0d busy_at_done=%b expected 18/19/0", n_busy, done_idx, done_busy);
        end
        n_checks++;
        if (rdata_at_done !== exp_done) begin
            n_fail++; $display("FAIL wr_rdata: got %h expected %h", rdata_at_done, exp_done);
        end
    endtask

    task automatic test_read();
        drive_start(RW_READ, 8'h22, 8'h00);
        watch_txn(0, 1'b0, 1'b0, 8'h00, 8'h00);
        n_checks++;
        if (n_addr_wr !== 4 || n_data_wr !== 0 || n_rd_low !== 4) begin
            n_fail++; $display("FAIL rd_strobes: addr_wr=%0d data_wr=%0d rd=%0d expected 4/0/4", n_addr_wr, n_data_wr, n_rd_low);
        end
        n_checks++;
        if (n_addr_bad !== 0 || n_float_bad !== 0) begin
            n_fail++; $display("FAIL rd_bus: addr_bad=%0d float_bad=%0d expected 0/0", n_addr_bad, n_float_bad);
        end
        n_checks++;
        if (done_idx !== 19 || rdata_at_done !== exp_done || exp_done !== 8'h59) begin
            n_fail++; $display("FAIL rd_data: done_at=%0d rdata=%h expected 19/%h", done_idx, rdata_at_done, exp_done);
        end
    endtask

    task automatic test_busy_reject();
        int extra_done;
        drive_start(RW_WRITE, 8'h21, 8'h45);
        watch_txn(5, 1'b0, 1'b0, 8'h00, 8'h00);
        extra_done = 0;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        n_checks++;
        if (n_addr_bad !== 0 || n_data_bad !== 0 || n_data_wr !== 4 || n_rd_low !== 0) begin
            n_fail++; $display("FAIL busy_reject_bus: addr_bad=%0d data_bad=%0d data_wr=%0d rd=%0d expected 0/0/4/0", n_addr_bad, n_data_bad, n_data_wr, n_rd_low);
        end
        n_checks++;
        if (done_idx !== 19 || extra_done !== 0 || rdata_at_done !== exp_done) begin
            n_fail++; $display("FAIL busy_reject_done: done_at=%0d extra=%0d rdata=%h expected 19/0/%h", done_idx, extra_done, rdata_at_done, exp_done);
        end
    endtask

    task automatic test_back_to_back();
        logic busy_in_done;
        drive_start(RW_WRITE, 8'h21, 8'h45);
        watch_txn(0, 1'b1, RW_READ, 8'h22, 8'h00);
        busy_in_done = done_busy;
        n_checks++;
        if (done_idx !== 19 || busy_in_done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first: done_at=%0d busy=%b expected 19/0", done_idx, busy_in_done);
        end
        watch_txn(0, 1'b0, 1'b0, 8'h00, 8'h00);
        n_checks++;
        if ({first_busy, first_cs, first_ad} !== 3'b100 || first_dato !== 8'h22) begin
            n_fail++; $display("FAIL b2b_restart: busy/cs/ad=%b dato=%h expected 100/22", {first_busy, first_cs, first_ad}, first_dato);
        end
        n_checks++;
        if (done_idx !== 19 || rdata_at_done !== exp_done) begin
            n_fail++; $display("FAIL b2b_second: done_at=%0d rdata=%h expected 19/%h", done_idx, rdata_at_done, exp_done);
        end
    endtask

    task automatic test_reset_mid();
        int late_done;
        drive_start(RW_WRITE, 8'h21, 8'h45);
        for (int j = 1; j <= 12; j++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({busy, done, reg_a_d, reg_cs, reg_rd, reg_wr} !== 6'b001111 || dato !== 8'hFF) begin
            n_fail++; $display("FAIL reset_mid_pins: got %b dato=%h expected 001111/FF", {busy, done, reg_a_d, reg_cs, reg_rd, reg_wr}, dato);
        end
        n_checks++;
        if (rdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_mid_rdata: got %h expected 00", rdata);
        end
        void'(sb_q.pop_front());
        model_rdata = 8'h00;
        late_done = 0;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            if (done) late_done++;
        end
        n_checks++;
        if (late_done !== 0) begin
            n_fail++; $display("FAIL reset_mid_no_done: got %0d expected 0", late_done);
        end
        drive_start(RW_READ, 8'h22, 8'h00);
        watch_txn(0, 1'b0, 1'b0, 8'h00, 8'h00);
        n_checks++;
        if (done_idx !== 19 || rdata_at_done !== exp_done) begin
            n_fail++; $display("FAIL reset_mid_fresh: done_at=%0d rdata=%h expected 19/%h", done_idx, rdata_at_done, exp_done);
        end
    endtask

    task automatic test_param_corner();
        logic [7:0] c_q[$];
        logic [7:0] c_exp;
        int nb, aw, dw, rl, idx;
        logic [7:0] got;
`ifdef RTC_BUS_TXN_CNT_EN
        logic [15:0] cnt_before, cnt_at_done;
`endif
        for (int t = 0; t < 2; t++) begin
            c_rw = (t == 1) ? RW_READ : RW_WRITE;
            c_addr = 8'h5A; c_wdata = 8'h3C; c_start = 1'b1;
            c_q.push_back((t == 1) ? 8'hA7 : 8'h00);
`ifdef RTC_BUS_TXN_CNT_EN
            cnt_before = c_txn_cnt; cnt_at_done = 16'hxxxx;
`endif
            @(posedge clk);
            #1 c_start = 1'b0;
            nb = 0; aw = 0; dw = 0; rl = 0; idx = -1; got = 8'hxx;
            for (int j = 1; j <= 20; j++) begin
                @(negedge clk);
                if (c_busy) nb++;
                if (c_wr == 1'b0 && c_a_d == 1'b0) aw++;
                if (c_wr == 1'b0 && c_a_d == 1'b1) dw++;
                if (c_rd == 1'b0) rl++;
                if (c_done) begin
                    idx = j; got = c_rdata;
`ifdef RTC_BUS_TXN_CNT_EN
                    cnt_at_done = c_txn_cnt;
`endif
                    break;
                end
            end
            c_exp = c_q.pop_front();
            n_checks++;
            if (nb !== 7 || idx !== 8) begin
                n_fail++; $display("FAIL corner_latency[%0d]: busy=%0d done_at=%0d expected 7/8", t, nb, idx);
            end
            n_checks++;
            if (aw !== 1 || dw !== ((t == 1) ? 0 : 1) || rl !== ((t == 1) ? 1 : 0)) begin
                n_fail++; $display("FAIL corner_strobes[%0d]: addr_wr=%0d data_wr=%0d rd=%0d", t, aw, dw, rl);
            end
            n_checks++;
            if (got !== c_exp) begin
                n_fail++; $display("FAIL corner_rdata[%0d]: got %h expected %h", t, got, c_exp);
            end
`ifdef RTC_BUS_TXN_CNT_EN
            n_checks++;
            if (cnt_at_done !== cnt_before + 16'd1) begin
                n_fail++; $display("FAIL corner_txn_cnt[%0d]: got %h expected %h", t, cnt_at_done, cnt_before + 16'd1);
            end
`endif
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid();
        test_param_corner();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
